// File: rtl/hazard_ctl_p.sv
// rtl/hazard_ctl_p.sv - hazard and forwarding controller over a DEPTH-slot destination scoreboard
// Optional feature: define HZ_PERF_EN for saturating stall/flush performance counters.
module hazard_ctl_p #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              pcrst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_wr,
    input  logic              id_load,
    input  logic              br_taken,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic              stall,
    output logic              flush
`ifdef HZ_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic [DEPTH:1]    s_v;
    logic [DEPTH:1]    s_wreg;
    logic [DEPTH:1]    s_load;
    logic [REG_AW-1:0] s_rd [1:DEPTH];
    logic              haz_a;
    logic              haz_b;

    // Scan oldest to youngest so the youngest matching slot wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_use_rs && s_v[k] && s_wreg[k] && (s_rd[k] == id_rs) && (id_rs != '0)) begin
                fwd_a = FW'(k);
                haz_a = s_load[k] && (k < LOAD_STAGE);
            end
            if (id_use_rt && s_v[k] && s_wreg[k] && (s_rd[k] == id_rt) && (id_rt != '0)) begin
                fwd_b = FW'(k);
                haz_b = s_load[k] && (k < LOAD_STAGE);
            end
        end
    end

    assign flush = br_taken;
    assign stall = id_valid && !br_taken && (haz_a || haz_b);

    always_ff @(posedge clk or negedge pcrst) begin
        if (!pcrst) begin
            s_v    <= '0;
            s_wreg <= '0;
            s_load <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                s_rd[k] <= '0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                s_v[k]    <= s_v[k-1];
                s_wreg[k] <= s_wreg[k-1];
                s_load[k] <= s_load[k-1];
                s_rd[k]   <= s_rd[k-1];
            end
            s_v[1]    <= id_valid && !stall && !flush;
            s_wreg[1] <= id_wreg;
            s_rd[1]   <= id_wr;
            s_load[1] <= id_load;
        end
    end

`ifdef HZ_PERF_EN
    always_ff @(posedge clk or negedge pcrst) begin
        if (!pcrst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctl_p.sv
// tb/tb_hazard_ctl_p.sv - scoreboard bench for hazard_ctl_p (default and DEPTH=4/LOAD_STAGE=3 instances)
module tb_hazard_ctl_p;

    logic       clk;
    logic       pcrst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wreg;
    logic [4:0] id_wr;
    logic       id_load;
    logic       br_taken;

    logic [1:0] fwd_a3, fwd_b3;
    logic       stall3, flush3;
    logic [2:0] fwd_a4, fwd_b4;
    logic       stall4, flush4;
`ifdef HZ_PERF_EN
    logic [31:0] stall_cnt3, flush_cnt3, stall_cnt4, flush_cnt4;
`endif

    hazard_ctl_p u_dut3 (
        .clk(clk), .pcrst(pcrst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wr(id_wr),
        .id_load(id_load), .br_taken(br_taken), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
        .stall(stall3), .flush(flush3)
`ifdef HZ_PERF_EN
        , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
    );

    hazard_ctl_p #(.DEPTH(4), .LOAD_STAGE(3)) u_dut4 (
        .clk(clk), .pcrst(pcrst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wr(id_wr),
        .id_load(id_load), .br_taken(br_taken), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
        .stall(stall4), .flush(flush4)
`ifdef HZ_PERF_EN
        , .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
`endif
    );

    typedef struct packed {
        logic       d4;
        logic [2:0] fa;
        logic [2:0] fb;
        logic       st;
        logic       fl;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    exp_t  m_e;
    string m_tag;
    int    n_cmp = 0;
    int    n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input string tag, input bit d4, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wreg,
                       input logic [4:0] wr, input logic ld, input logic br,
                       input logic [2:0] efa, input logic [2:0] efb,
                       input logic est, input logic efl);
        exp_t e;
        @(negedge clk);
        pcrst     = 1'b1;
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_wreg   = wreg;
        id_wr     = wr;
        id_load   = ld;
        br_taken  = br;
        e = '{d4: d4, fa: efa, fb: efb, st: est, fl: efl};
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic rst_cycle(input string tag, input bit d4, input logic br, input logic efl);
        exp_t e;
        @(negedge clk);
        pcrst     = 1'b0;
        id_valid  = 1'b1;
        id_rs     = 5'd3;
        id_rt     = 5'd3;
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
        id_wreg   = 1'b0;
        id_wr     = 5'd0;
        id_load   = 1'b0;
        br_taken  = br;
        e = '{d4: d4, fa: 3'd0, fb: 3'd0, st: 1'b0, fl: efl};
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            m_e   = sb.pop_front();
            m_tag = tq.pop_front();
            if (m_e.d4) begin
                check({m_tag, ".fwd_a"}, 32'(fwd_a4), 32'(m_e.fa));
                check({m_tag, ".fwd_b"}, 32'(fwd_b4), 32'(m_e.fb));
                check({m_tag, ".stall"}, 32'(stall4), 32'(m_e.st));
                check({m_tag, ".flush"}, 32'(flush4), 32'(m_e.fl));
            end else begin
                check({m_tag, ".fwd_a"}, 32'(fwd_a3), 32'(m_e.fa));
                check({m_tag, ".fwd_b"}, 32'(fwd_b3), 32'(m_e.fb));
                check({m_tag, ".stall"}, 32'(stall3), 32'(m_e.st));
                check({m_tag, ".flush"}, 32'(flush3), 32'(m_e.fl));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 20000);
        $fatal(1);
    end

    initial begin
        pcrst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_wreg = 1'b0; id_wr = '0; id_load = 1'b0; br_taken = 1'b0;

        rst_cycle("rst_idle", 0, 1'b0, 1'b0);
        rst_cycle("rst_br",   0, 1'b1, 1'b1);
        //          tag          d4 v  rs     rt     urs urt wreg wr     ld br   fa fb st fl
        drv("add3",       0, 1, 5'd1, 5'd2, 1, 1, 1, 5'd3,  0, 0,  0, 0, 0, 0);
        drv("sub_fwd1",   0, 1, 5'd3, 5'd5, 1, 1, 1, 5'd4,  0, 0,  1, 0, 0, 0);
        drv("use3_fwd2",  0, 1, 5'd3, 5'd3, 1, 1, 1, 5'd6,  0, 0,  2, 2, 0, 0);
        drv("use3_fwd3",  0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0,  0, 0,  3, 0, 0, 0);
        drv("use3_rf",    0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0,  0, 0,  0, 0, 0, 0);
        drv("lw2",        0, 1, 5'd1, 5'd0, 1, 0, 1, 5'd2,  1, 0,  0, 0, 0, 0);
        drv("lu_stall",   0, 1, 5'd2, 5'd2, 1, 1, 1, 5'd6,  0, 0,  1, 1, 1, 0);
        drv("lu_after",   0, 1, 5'd2, 5'd2, 1, 1, 1, 5'd6,  0, 0,  2, 2, 0, 0);
        drv("w7_a",       0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd7,  0, 0,  0, 0, 0, 0);
        drv("w8",         0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd8,  0, 0,  0, 0, 0, 0);
        drv("w7_b",       0, 1, 5'd0, 5'd7, 0, 1, 1, 5'd7,  0, 0,  0, 2, 0, 0);
        drv("young7",     0, 1, 5'd8, 5'd7, 1, 1, 0, 5'd0,  0, 0,  2, 1, 0, 0);
        drv("ld_r0",      0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd0,  1, 0,  0, 0, 0, 0);
        drv("use_r0",     0, 1, 5'd0, 5'd0, 1, 1, 0, 5'd0,  0, 0,  0, 0, 0, 0);
        drv("lw9",        0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd9,  1, 0,  0, 0, 0, 0);
        drv("lu_br",      0, 1, 5'd9, 5'd0, 1, 0, 1, 5'd10, 0, 1,  1, 0, 0, 1);
        drv("post_br",    0, 1, 5'd9, 5'd10, 1, 1, 0, 5'd0, 0, 0,  2, 0, 0, 0);
        drv("lw11",       0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd11, 1, 0,  0, 0, 0, 0);
        drv("lu_11",      0, 1, 5'd11, 5'd0, 1, 0, 0, 5'd0, 0, 0,  1, 0, 1, 0);
        #3 pcrst = 1'b0;
        #1;
        check("rst_mid_stall.stall", 32'(stall3), 32'd0);
        check("rst_mid_stall.fwd_a", 32'(fwd_a3), 32'd0);

        rst_cycle("rst_d4", 1, 1'b0, 1'b0);
        drv("lw2_d4",     1, 1, 5'd0, 5'd0, 0, 0, 1, 5'd2,  1, 0,  0, 0, 0, 0);
        drv("lu4_s1",     1, 1, 5'd2, 5'd2, 1, 1, 0, 5'd0,  0, 0,  1, 1, 1, 0);
        drv("lu4_s2",     1, 1, 5'd2, 5'd2, 1, 1, 0, 5'd0,  0, 0,  2, 2, 1, 0);
        drv("lu4_done",   1, 1, 5'd2, 5'd2, 1, 1, 0, 5'd0,  0, 0,  3, 3, 0, 0);
`ifdef HZ_PERF_EN
        #3;
        check("perf.stall_cnt", stall_cnt4, 32'd2);
        check("perf.flush_cnt0", flush_cnt4, 32'd0);
`endif
        drv("br4",        1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0,  0, 1,  0, 0, 0, 1);
        drv("lw5_d4",     1, 1, 5'd0, 5'd0, 0, 0, 1, 5'd5,  1, 0,  0, 0, 0, 0);
        drv("lu5_d4",     1, 1, 5'd5, 5'd0, 1, 0, 0, 5'd0,  0, 0,  1, 0, 1, 0);
        #3;
`ifdef HZ_PERF_EN
        check("perf.stall_cnt_hold", stall_cnt4, 32'd2);
        check("perf.flush_cnt1", flush_cnt4, 32'd1);
`endif
        pcrst = 1'b0;
        #1;
        check("rst4_mid.stall", 32'(stall4), 32'd0);
        check("rst4_mid.fwd_a", 32'(fwd_a4), 32'd0);
`ifdef HZ_PERF_EN
        check("rst4_mid.stall_cnt", stall_cnt4, 32'd0);
        check("rst4_mid.flush_cnt", flush_cnt4, 32'd0);
`endif
        drv("after_rst4", 1, 1, 5'd5, 5'd0, 1, 0, 0, 5'd0,  0, 0,  0, 0, 0, 0);
        @(negedge clk);
        #3;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctl_p.md
# hazard_ctl_p

Parametrised hazard and forwarding controller for the pipelined CPU. It replaces the fixed EX/MEM forwarding and load-use logic that lives in the control unit. The block keeps a shift-register scoreboard of the in-flight destination registers over `DEPTH` post-decode stages. From it, it produces per-operand forwarding selects, a load-use stall and a branch flush for the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- `REG_AW`, 5: register-address width.
- `DEPTH`, 3: post-decode slots tracked. Slot 1 = EX, 2 = MEM, 3 = WB. Minimum 2.
- `LOAD_STAGE`, 2: first slot whose result bus carries load data. Range 1..`DEPTH`.
- `FW`, `$clog2(DEPTH+1)`: derived forwarding-select width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `pcrst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in `REG_AW`: ID source registers.
- `id_use_rs`, `id_use_rt` in 1: the operand is actually read.
- `id_wreg` in 1: the ID instruction writes a register.
- `id_wr` in `REG_AW`: ID destination register.
- `id_load` in 1: the ID instruction is a load.
- `br_taken` in 1: branch/jump resolved taken in EX this cycle.
- `fwd_a`, `fwd_b` out `FW`: 0 = register file; k = result bus of slot k.
- `stall` out 1: hold PC and IF/ID; insert a bubble into ID/EX.
- `flush` out 1: clear IF/ID and ID/EX.
- `stall_cnt`, `flush_cnt` out 32: performance counters. Present only with `HZ_PERF_EN`.

## Operation
- Each scoreboard slot holds `{v, wreg, rd, load}`.
- A slot is a candidate producer for an operand when `v & wreg & rd == operand & operand != 0`.
- `fwd_x` is the lowest-numbered (youngest) candidate slot. It is 0 when there is no candidate or when `id_use_x = 0`.
- Load-use: `stall = id_valid & ~br_taken` and, for either used operand, the youngest candidate has `load = 1` and a slot index below `LOAD_STAGE`. While `stall` is high, `fwd_a` and `fwd_b` still show the computed selects; the consumer ignores them.
- `flush = br_taken`. Flush dominates stall: if both conditions hold, `stall = 0`.
- Next-state update on each rising edge:
  - Slots k = 2..`DEPTH` take the contents of slot k-1. Slot `DEPTH` drops out.
  - Slot 1 takes `{id_valid, id_wreg, id_wr, id_load}` when `stall` and `flush` are both low.
  - Otherwise slot 1 takes a bubble, `v = 0`.
- Register 0 never matches, even when `id_wr = 0` and `wreg = 1`.
- `stall`, `flush`, `fwd_a` and `fwd_b` are combinational from the slot state and the ID inputs. There are no combinational paths between `stall` and `flush` other than the flush-dominance rule.

## Timing
- Reset (asynchronous, `pcrst = 0`): all slots `v = 0`, counters 0. Outputs settle to `stall = 0`, `fwd = 0`, and `flush = br_taken`.
- Reset mid-stall: the stall clears immediately because the slots are cleared.
- Forward latency: a producer entering ID in cycle n is visible as slot 1 in cycle n+1.
- Load-use stall length: `LOAD_STAGE - k` cycles for a producer currently in slot k. With the defaults, one cycle for a back-to-back load-use.
- A slot's producer is forwardable for exactly `DEPTH` cycles. After that the register file (write on falling edge) supplies the value.

## Configuration
- With `HZ_PERF_EN` defined:
  - `stall_cnt` increments on each rising edge where `stall = 1`.
  - `flush_cnt` increments on each rising edge where `flush = 1`.
  - Both are 32-bit, saturate at `32'hFFFFFFFF`, and reset to 0.
- Without `HZ_PERF_EN`: both ports and their registers are absent.

## Test plan
- Defaults; `add $3,...` then `sub $4,$3,$5` on consecutive cycles -> `fwd_a = 1`, `stall = 0`. One cycle later, a consumer of `$3` sees `fwd = 2`.
- `lw $2` then `add $6,$2,$2` back-to-back -> `stall = 1` for exactly 1 cycle. After it, `fwd_a = fwd_b = 2`, and slot 1 holds a bubble.
- Producers of `$7` in slots 1 and 3, consumer reads `$7` as rt -> `fwd_b = 1` (youngest wins).
- Producer writes `$0` with `wreg = 1`, consumer reads `$0` -> `fwd = 0`, `stall = 0`.
- Load-use condition and `br_taken = 1` in the same cycle -> `flush = 1`, `stall = 0`, slot 1 holds a bubble next cycle.
- `HZ_PERF_EN`, `DEPTH = 4`, `LOAD_STAGE = 3`: a load followed immediately by its consumer gives 2 stall cycles and `stall_cnt = 2`. Then assert `pcrst = 0` mid-operation -> counters and slots read 0 before the next clock edge.
